// File: rtl/polirv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and byte-lane helpers.
package polirv_pkg;

  // Bytes per 32-bit instruction word.
  localparam int unsigned ByteLanes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StFlush,
    StDone
  } ld_state_e;

  // Place a byte into its little-endian lane of a word under assembly.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [7:0]  byte_in,
                                              input logic [1:0]  lane);
    return word | (32'(byte_in) << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port, no reset.
module imem_array #(
  parameter int unsigned WordBits = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [WordBits-1:0] waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [WordBits-1:0] raddr_i,
  output logic [31:0]         rdata_o
);

  localparam int unsigned Depth = 1 << WordBits;

  logic [31:0] mem_q [Depth];

  // Write port; a same-cycle read of this index still sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the core while a session is active.
module imem_loader
  import polirv_pkg::*;
#(
  parameter int unsigned i_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [i_addr_bits-1:0] i_mem_addr,
  output logic [31:0]            i_mem_data,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   cpu_hold,
  output logic                   ld_err
);

  localparam int unsigned WordBits = i_addr_bits - 2;
  localparam int unsigned Depth    = 1 << WordBits;
  localparam logic [WordBits:0] PtrMax = (WordBits + 1)'(Depth);
  localparam logic [WordBits:0] PtrOne = (WordBits + 1)'(1);
  localparam logic [1:0]        LastLane = 2'(ByteLanes - 1);

  ld_state_e         state_q, state_d;
  logic [WordBits:0] ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              wr_en;
  logic              accept;
  logic              full;
  logic              unused_addr_lsbs;

  // Pointer at depth means every word is written; later bytes are dropped.
  assign full             = (ptr_q == PtrMax);
  assign accept           = ld_valid & ld_ready;
  assign unused_addr_lsbs = ^i_mem_addr[1:0];
  assign ld_err           = err_q;

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    err_d    = err_q;
    last_d   = last_q;
    wr_en    = 1'b0;
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      StLoad: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (accept) begin
          asm_d = lane_insert(asm_q, ld_data, cnt_q);
          if (full) begin
            err_d = 1'b1;
          end
          if (cnt_q == LastLane) begin
            last_d  = ld_last;
            state_d = StWrite;
          end else begin
            cnt_d = cnt_q + 2'd1;
            if (ld_last) begin
              state_d = StFlush;
            end
          end
        end
      end
      StWrite: begin
        cpu_hold = 1'b1;
        wr_en    = ~full;
        ptr_d    = full ? ptr_q : ptr_q + PtrOne;
        cnt_d    = '0;
        asm_d    = '0;
        state_d  = last_q ? StDone : StLoad;
      end
      StFlush: begin
        cpu_hold = 1'b1;
        wr_en    = ~full;
        cnt_d    = '0;
        asm_d    = '0;
        state_d  = StDone;
      end
      StDone: begin
        cpu_hold = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset abandons any session in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  imem_array #(
    .WordBits(WordBits)
  ) u_array (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(ptr_q[WordBits-1:0]),
    .wdata_i(asm_q),
    .raddr_i(i_mem_addr[i_addr_bits-1:2]),
    .rdata_o(i_mem_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (depth 16 and depth 4) share one byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr6;
  logic [3:0]  addr4;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_data;
  logic [31:0] data6, data4;
  logic        ready6, hold6, err6, ready4, hold4, err4;

  int total = 0;
  int bad   = 0;

  // Reference model: word contents and whether each word has ever been written.
  logic [31:0] m6 [16];
  logic        k6 [16];
  logic [31:0] m4 [4];
  logic        k4 [4];
  logic [7:0]  sess [$];
  logic [7:0]  stim [$];

  int run = 0;
  int last_run = 0;

  assign addr4 = addr6[3:0];

  always #5 clk = ~clk;

  imem_loader u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .i_mem_addr(addr6),
    .i_mem_data(data6),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ready6),
    .cpu_hold  (hold6),
    .ld_err    (err6)
  );

  imem_loader #(
    .i_addr_bits(4)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .i_mem_addr(addr4),
    .i_mem_data(data4),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ready4),
    .cpu_hold  (hold4),
    .ld_err    (err4)
  );

  // Length of the most recent cpu_hold pulse, in cycles.
  always @(negedge clk) begin
    if (hold6) begin
      run <= run + 1;
    end else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic hold);
    chk({tag, "_rdy6"}, 32'(ready6), 32'(rdy));
    chk({tag, "_hold6"}, 32'(hold6), 32'(hold));
    chk({tag, "_rdy4"}, 32'(ready4), 32'(rdy));
    chk({tag, "_hold4"}, 32'(hold4), 32'(hold));
  endtask

  // Byte i of a session lands in word i/4, lane i%4; words beyond depth are never written.
  task automatic commit(input int n, input bit at_end);
    int nw;
    logic [31:0] w;
    nw = at_end ? (n + 3) / 4 : n / 4;
    for (int wi = 0; wi < nw; wi++) begin
      w = 32'h0;
      for (int l = 0; l < 4; l++) begin
        if (wi * 4 + l < n) w[l*8 +: 8] = sess[wi*4 + l];
      end
      if (wi < 16) begin m6[wi] = w; k6[wi] = 1'b1; end
      if (wi < 4)  begin m4[wi] = w; k4[wi] = 1'b1; end
    end
  endtask

  task automatic check_mem();
    for (int w = 0; w < 16; w++) begin
      addr6 = {w[3:0], 2'($urandom)};
      #1;
      if (k6[w])     chk($sformatf("rd6_w%0d", w), data6, m6[w]);
      if (k4[w % 4]) chk($sformatf("rd4_w%0d", w % 4), data4, m4[w % 4]);
      @(negedge clk);
    end
  endtask

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap, input bit spur);
    int t;
    ld_valid = 1'b0;
    repeat (gap) begin
      ld_start = spur;
      @(negedge clk);
    end
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    t = 0;
    while (!ready6 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("byte_ready", 32'(ready6), 32'd1);
    @(posedge clk);
    sess.push_back(b);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_session(input int g0, input int maxgap, input bit spur);
    int n;
    n = stim.size();
    sess.delete();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk_ctl("entry", 1'b1, 1'b1);
    chk("err_clr6", 32'(err6), 32'd0);
    chk("err_clr4", 32'(err4), 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(stim[i], i == n - 1, (i == 0) ? g0 : int'($urandom_range(0, maxgap)), spur);
    end
    // Last byte: one write cycle, one done cycle, then back to idle.
    chk_ctl("write", 1'b0, 1'b1);
    @(negedge clk);
    chk_ctl("done", 1'b0, 1'b1);
    @(negedge clk);
    chk_ctl("idle", 1'b0, 1'b0);
    commit(n, 1'b1);
    chk("err6", 32'(err6), 32'(n > 64));
    chk("err4", 32'(err4), 32'(n > 16));
    check_mem();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) k6[i] = 1'b0;
    for (int i = 0; i < 4; i++)  k4[i] = 1'b0;
    rst      = 1'b1;
    addr6    = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    #1;
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset_err6", 32'(err6), 32'd0);
    chk("reset_err4", 32'(err4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // One empty load cycle, four bytes, write, done: seven held cycles.
    stim = '{8'h13, 8'h00, 8'h50, 8'h00};
    run_session(1, 0, 1'b0);
    addr6 = 6'd0;
    #1;
    chk("req030_w0", data6, 32'h00500013);
    chk("req030_hold", 32'(last_run), 32'd7);
    @(negedge clk);

    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_session(0, 0, 1'b0);
    addr6 = 6'd0;
    #1 chk("req031_w0", data6, 32'h04030201);
    addr6 = 6'd4;
    #1 chk("req031_a4", data6, 32'h08070605);
    addr6 = 6'd7;
    #1 chk("req031_a7", data6, 32'h08070605);
    @(negedge clk);

    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_session(0, 1, 1'b0);
    addr6 = 6'd4;
    #1 chk("req032_w1", data6, 32'h0000FFEE);
    @(negedge clk);

    // Twenty bytes overflow the depth-4 instance only.
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h30 + i));
    run_session(0, 1, 1'b0);
    chk("req033_err4", 32'(err4), 32'd1);
    chk("req033_err6", 32'(err6), 32'd0);
    addr6 = 6'd12;
    #1 chk("req033_w3", data4, 32'h3F3E3D3C);
    @(negedge clk);

    // Spurious starts during gaps must not disturb the session.
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(8'($urandom));
    run_session(2, 3, 1'b1);

    // Reset two bytes into the second word: first word kept, partial word lost.
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    sess.delete();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(stim[i], 1'b0, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk_ctl("req034_async", 1'b0, 1'b0);
    chk("req034_err6", 32'(err6), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    commit(6, 1'b0);
    @(negedge clk);
    chk_ctl("req034_idle", 1'b0, 1'b0);
    check_mem();

    // Saturate the depth-16 instance too.
    stim.delete();
    for (int i = 0; i < 68; i++) stim.push_back(8'($urandom));
    run_session(0, 0, 1'b0);

    for (int s = 0; s < 25; s++) begin
      stim.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) stim.push_back(8'($urandom));
      run_session(int'($urandom_range(0, 2)), 2, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
